dcache_mem_ctrl: RTL and testbench
==================================

# dcache_mem_ctrl

Memory-side controller for the write-back, no-write-allocate dcache. It accepts the dcache's three miss/eviction request streams: dirty writeback, write-miss store and read miss. It serializes them onto the single tagged memory port and tracks outstanding loads in a small miss table. On load return it drives the dcache fill port and wakes the waiting LSQ entries.

## Interface
- `NUM_MSHR`, 4: outstanding load-miss entries.
- `STQ_DEPTH`, 4: store FIFO depth (writebacks and write misses); must be ≥2.
- `clock` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `wb_en`, `wb_addr`, `wb_data`, `wb_size` in 1/16/64/2: dirty-victim writeback from dcache.
- `wr_en`, `wr_addr`, `wr_data`, `wr_size` in 1/16/64/2: write-miss store from dcache.
- `rd_en`, `rd_addr`, `rd_size`, `rd_gnt` in 1/16/2/`LSQSZ`: read miss; `rd_addr[2:0]`=0.
- `mem_busy` out 1: LSQ must not issue; high when FIFO free slots <2 or no free MSHR.
- `overflow_err` out 1: sticky, set when a request arrives with no space.
- `fill_en`, `fill_idx`, `fill_tag`, `fill_data` out 1/5/8/64: to dcache `mem_wr_*`.
- `fill_gnt` out `LSQSZ`: LSQ wakeup vector for replay.
- `proc2mem_command` out 2: BUS_NONE/BUS_LOAD/BUS_STORE.
- `proc2mem_addr` out 32: `{16'b0, addr}`.
- `proc2mem_data` out 64: store data.
- `proc2mem_size` out 2: access size.
- `mem2proc_response` in 4: nonzero means the command was accepted; the value is its tag.
- `mem2proc_data` in 64: load return data.
- `mem2proc_tag` in 4: nonzero means load data for this tag.

## Operation
- Store FIFO: each cycle push `wb` then `wr` (both may push in the same cycle, wb older). A push while full is dropped and sets `overflow_err`.
- MSHR entry fields: valid, issued, stale, mem_tag[3:0], blk[15:3], gnt[`LSQSZ`-1:0].
- Read miss handling:
  - Match on valid entry with `blk == rd_addr[15:3]`: OR `rd_gnt` into that entry's gnt, no new request.
  - Otherwise allocate the lowest free entry (issued=0, stale=0).
  - No free entry: drop the request and set `overflow_err`.
- Issue arbitration, one command per cycle:
  - FIFO non-empty: present its head as BUS_STORE.
  - Else the lowest-index valid, unissued MSHR: BUS_LOAD, `proc2mem_size`=DOUBLE.
  - Stores strictly first; this guarantees read-after-write order.
- A command is held stable until `mem2proc_response != 0`. On accept:
  - Store: pop the FIFO.
  - Load: set issued, latch mem_tag.
- Store hazard: pushing a store (wb or wr) whose `addr[15:3]` matches a valid issued MSHR sets that entry's stale bit.
- Response (`mem2proc_tag != 0`) matching an issued entry:
  - Free the entry.
  - Next cycle: `fill_gnt` = entry gnt; `fill_en` = !stale; `fill_idx` = blk[7:3]; `fill_tag` = blk[15:8]; `fill_data` = `mem2proc_data`.
  - A stale entry only wakes the LSQ, which replays.
- Same-cycle read whose block matches the retiring entry: OR `rd_gnt` into the registered `fill_gnt`; no allocation.
- An unmatched or zero tag is ignored.

## Timing
- Reset (async assert, sync deassert):
  - FIFO empty, all MSHRs invalid, all outputs 0, `proc2mem_command`=BUS_NONE.
  - Reset mid-transaction discards all in-flight state; responses after reset match nothing.
- Request to command: a request in cycle N may appear on `proc2mem_*` at the earliest in cycle N+1; memory is driven from registers.
- Fill latency: tag return in cycle N → `fill_*` valid for exactly cycle N+1.
- `mem_busy` is combinational from registered occupancy; it is valid in the same cycle.
- FIFO pointers wrap modulo `STQ_DEPTH`. Push and pop on the same cycle when full: the pop frees a slot, then the push succeeds.

## Structure
- Shared package holds BUS_NONE/BUS_LOAD/BUS_STORE, the memory-size encoding (BYTE/HALF/WORD/DOUBLE) and `LSQSZ`.
- One sub-module, `dmem_store_fifo`: two-write-port / one-read-port FIFO with full/free-count outputs.

## Test plan
- Store priority: `wb_en` at 0x0120 and `wr_en` at 0x0348 in the same cycle, response 1 each cycle → two BUS_STORE commands, wb first, then empty FIFO.
- Load round trip: `rd_en` 0x1A08, gnt=0b0010, accept tag 3, return tag 3 data 0xDEAD… → next cycle `fill_en`=1, idx=1, tag=0x1A, `fill_gnt`=0b0010.
- Merge: two reads to 0x1A08 with gnt 0b0001 then 0b0100 → one BUS_LOAD, `fill_gnt`=0b0101.
- Stale: load 0x0200 issued, then `wr_en` 0x0204 → on return `fill_en`=0, `fill_gnt` nonzero.
- Backpressure and reset: response held 0 for 5 cycles → command stable. Fill all MSHRs → `mem_busy`=1; an extra read sets `overflow_err`. Deassert `reset_n` mid-flight → all cleared; a late tag causes no fill.

Source files
------------

// File: rtl/dcache_mem_ctrl_pkg.sv
// dcache_mem_ctrl_pkg
//   Shared types for the dcache memory-side controller: memory bus command
//   and size encodings, LSQ width, store FIFO entry and miss-table entry.
package dcache_mem_ctrl_pkg;

    localparam int LSQSZ = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } bus_cmd_e;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } mem_size_e;

    typedef struct packed {
        logic [15:0] addr;
        logic [63:0] data;
        logic [1:0]  size;
    } stq_entry_t;

    typedef struct packed {
        logic             valid;
        logic             issued;
        logic             stale;
        logic [3:0]       mem_tag;
        logic [12:0]      blk;
        logic [LSQSZ-1:0] gnt;
    } mshr_t;

endpackage

// File: rtl/dmem_store_fifo.sv
// dmem_store_fifo
//   Store FIFO with two write ports (port 0 is older) and one read port.
//   Ports:
//     i_clock, i_reset_n        : clock, async active-low reset
//     i_push0/i_data0           : older push (dirty writeback)
//     i_push1/i_data1           : younger push (write-miss store)
//     i_pop                     : remove head (ignored when empty)
//     o_head, o_empty, o_full   : head entry and status
//     o_free                    : free slots from registered occupancy
//     o_drop                    : a push was dropped this cycle for lack of space
module dmem_store_fifo
    import dcache_mem_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    input  logic          i_push0,
    input  stq_entry_t    i_data0,
    input  logic          i_push1,
    input  stq_entry_t    i_data1,
    input  logic          i_pop,
    output stq_entry_t    o_head,
    output logic          o_empty,
    output logic          o_full,
    output logic [CW-1:0] o_free,
    output logic          o_drop
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    stq_entry_t    r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          w_pop;
    logic [CW-1:0] w_free;
    logic [CW-1:0] w_free_eff;
    logic          w_acc0;
    logic          w_acc1;
    logic [PW-1:0] w_wr_idx1;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        f_next = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A pop in the same cycle frees its slot before the pushes are judged.
    assign w_pop      = i_pop && (r_count != '0);
    assign w_free     = DEPTH_C - r_count;
    assign w_free_eff = w_free + CW'(w_pop);
    assign w_acc0     = i_push0 && (w_free_eff != '0);
    assign w_acc1     = i_push1 && (w_free_eff > CW'(w_acc0));
    assign w_wr_idx1  = w_acc0 ? f_next(r_wr_ptr) : r_wr_ptr;

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == DEPTH_C);
    assign o_free  = w_free;
    assign o_drop  = (i_push0 && !w_acc0) || (i_push1 && !w_acc1);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_acc0) r_mem[r_wr_ptr] <= i_data0;
            if (w_acc1) r_mem[w_wr_idx1] <= i_data1;
            if (w_acc0 && w_acc1)      r_wr_ptr <= f_next(f_next(r_wr_ptr));
            else if (w_acc0 || w_acc1) r_wr_ptr <= f_next(r_wr_ptr);
            if (w_pop) r_rd_ptr <= f_next(r_rd_ptr);
            r_count <= r_count - CW'(w_pop) + CW'(w_acc0) + CW'(w_acc1);
        end
    end

endmodule

// File: rtl/dcache_mem_ctrl.sv
// dcache_mem_ctrl
//   Serializes dcache writebacks, write-miss stores and read misses onto one
//   tagged memory port; tracks outstanding loads in a miss table and drives
//   the dcache fill port plus an LSQ wakeup vector on load return.
//   Ports:
//     clock, reset_n               : clock, async active-low reset
//     wb_* / wr_*                  : store requests into the store FIFO
//     rd_*                         : read-miss requests into the miss table
//     mem_busy, overflow_err       : backpressure and sticky drop flag
//     fill_*                       : registered fill/wakeup, one cycle per return
//     proc2mem_*                   : registered memory command, held until accepted
//     mem2proc_*                   : accept tag, return tag and return data
//   Handshake: a command on proc2mem_* is held unchanged until a cycle with
//   mem2proc_response != 0; that cycle is the transfer, and the next cycle
//   presents BUS_NONE before the next command is chosen.
module dcache_mem_ctrl
    import dcache_mem_ctrl_pkg::*;
#(
    parameter int NUM_MSHR  = 4,
    parameter int STQ_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wb_en,
    input  logic [15:0]      wb_addr,
    input  logic [63:0]      wb_data,
    input  logic [1:0]       wb_size,
    input  logic             wr_en,
    input  logic [15:0]      wr_addr,
    input  logic [63:0]      wr_data,
    input  logic [1:0]       wr_size,
    input  logic             rd_en,
    input  logic [15:0]      rd_addr,
    input  logic [1:0]       rd_size,
    input  logic [LSQSZ-1:0] rd_gnt,
    output logic             mem_busy,
    output logic             overflow_err,
    output logic             fill_en,
    output logic [4:0]       fill_idx,
    output logic [7:0]       fill_tag,
    output logic [63:0]      fill_data,
    output logic [LSQSZ-1:0] fill_gnt,
    output logic [1:0]       proc2mem_command,
    output logic [31:0]      proc2mem_addr,
    output logic [63:0]      proc2mem_data,
    output logic [1:0]       proc2mem_size,
    input  logic [3:0]       mem2proc_response,
    input  logic [63:0]      mem2proc_data,
    input  logic [3:0]       mem2proc_tag
);

    localparam int IW = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;
    localparam int CW = $clog2(STQ_DEPTH + 1);

    mshr_t            r_mshr [NUM_MSHR];
    bus_cmd_e         r_cmd;
    logic [15:0]      r_addr;
    logic [63:0]      r_data;
    logic [1:0]       r_size;
    logic [IW-1:0]    r_cmd_idx;
    logic             r_fill_en;
    logic [4:0]       r_fill_idx;
    logic [7:0]       r_fill_tag;
    logic [63:0]      r_fill_data;
    logic [LSQSZ-1:0] r_fill_gnt;
    logic             r_overflow;

    stq_entry_t       w_wb_ent, w_wr_ent, w_head;
    logic             w_fifo_empty, w_fifo_full, w_fifo_drop;
    logic [CW-1:0]    w_fifo_free;
    logic             w_accept, w_pop;
    logic             w_match_found, w_free_found, w_ret_found, w_iss_found;
    logic [IW-1:0]    w_match_idx, w_free_idx, w_ret_idx, w_iss_idx;
    logic [NUM_MSHR-1:0] w_hazard;
    mshr_t            w_ret_ent;
    logic             w_rd_retire_merge;
    logic             w_unused;

    // Loads are always whole-block, so the low address bits and size are not needed.
    assign w_unused = ^{rd_addr[2:0], rd_size};

    assign w_wb_ent = '{addr: wb_addr, data: wb_data, size: wb_size};
    assign w_wr_ent = '{addr: wr_addr, data: wr_data, size: wr_size};
    assign w_accept = (r_cmd != BUS_NONE) && (mem2proc_response != 4'h0);
    assign w_pop    = w_accept && (r_cmd == BUS_STORE);

    dmem_store_fifo #(.DEPTH(STQ_DEPTH)) u_store_fifo (
        .i_clock   (clock),
        .i_reset_n (reset_n),
        .i_push0   (wb_en),
        .i_data0   (w_wb_ent),
        .i_push1   (wr_en),
        .i_data1   (w_wr_ent),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_empty   (w_fifo_empty),
        .o_full    (w_fifo_full),
        .o_free    (w_fifo_free),
        .o_drop    (w_fifo_drop)
    );

    // Descending scans so the lowest matching index wins.
    always_comb begin
        w_match_found = 1'b0; w_match_idx = '0;
        w_free_found  = 1'b0; w_free_idx  = '0;
        w_ret_found   = 1'b0; w_ret_idx   = '0;
        w_iss_found   = 1'b0; w_iss_idx   = '0;
        w_hazard      = '0;
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (r_mshr[i].valid && r_mshr[i].blk == rd_addr[15:3]) begin
                w_match_found = 1'b1; w_match_idx = IW'(i);
            end
            if (!r_mshr[i].valid) begin
                w_free_found = 1'b1; w_free_idx = IW'(i);
            end
            if (r_mshr[i].valid && r_mshr[i].issued && mem2proc_tag != 4'h0 &&
                r_mshr[i].mem_tag == mem2proc_tag) begin
                w_ret_found = 1'b1; w_ret_idx = IW'(i);
            end
            if (r_mshr[i].valid && !r_mshr[i].issued) begin
                w_iss_found = 1'b1; w_iss_idx = IW'(i);
            end
            // A load already on the bus counts as issued: memory may
            // order it ahead of a store pushed now.
            w_hazard[i] = r_mshr[i].valid &&
                          (r_mshr[i].issued || (r_cmd == BUS_LOAD && r_cmd_idx == IW'(i))) &&
                          ((wb_en && wb_addr[15:3] == r_mshr[i].blk) ||
                           (wr_en && wr_addr[15:3] == r_mshr[i].blk));
        end
    end

    assign w_ret_ent         = r_mshr[w_ret_idx];
    assign w_rd_retire_merge = rd_en && w_match_found && w_ret_found && (w_match_idx == w_ret_idx);

    assign mem_busy = w_fifo_full || (w_fifo_free < CW'(2)) || !w_free_found;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_MSHR; i++) r_mshr[i] <= '0;
            r_cmd       <= BUS_NONE;
            r_addr      <= '0;
            r_data      <= '0;
            r_size      <= '0;
            r_cmd_idx   <= '0;
            r_fill_en   <= 1'b0;
            r_fill_idx  <= '0;
            r_fill_tag  <= '0;
            r_fill_data <= '0;
            r_fill_gnt  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            // A store pushed in the retiring cycle also makes the returned data stale.
            r_fill_en   <= w_ret_found && !(w_ret_ent.stale || w_hazard[w_ret_idx]);
            r_fill_idx  <= w_ret_found ? w_ret_ent.blk[4:0]  : '0;
            r_fill_tag  <= w_ret_found ? w_ret_ent.blk[12:5] : '0;
            r_fill_data <= w_ret_found ? mem2proc_data       : '0;
            r_fill_gnt  <= w_ret_found ? (w_ret_ent.gnt | (w_rd_retire_merge ? rd_gnt : '0)) : '0;

            for (int i = 0; i < NUM_MSHR; i++)
                if (w_hazard[i]) r_mshr[i].stale <= 1'b1;
            if (w_ret_found) r_mshr[w_ret_idx].valid <= 1'b0;
            if (w_accept && r_cmd == BUS_LOAD) begin
                r_mshr[r_cmd_idx].issued  <= 1'b1;
                r_mshr[r_cmd_idx].mem_tag <= mem2proc_response;
            end

            if (rd_en) begin
                if (w_match_found) begin
                    if (!w_rd_retire_merge)
                        r_mshr[w_match_idx].gnt <= r_mshr[w_match_idx].gnt | rd_gnt;
                end else if (w_free_found) begin
                    r_mshr[w_free_idx] <= '{valid: 1'b1, issued: 1'b0, stale: 1'b0,
                                            mem_tag: 4'h0, blk: rd_addr[15:3], gnt: rd_gnt};
                end
            end

            if (w_fifo_drop || (rd_en && !w_match_found && !w_free_found))
                r_overflow <= 1'b1;

            // Stores always win arbitration, which keeps reads behind older writes.
            if (w_accept) begin
                r_cmd  <= BUS_NONE;
                r_addr <= '0;
                r_data <= '0;
                r_size <= '0;
            end else if (r_cmd == BUS_NONE) begin
                if (!w_fifo_empty) begin
                    r_cmd  <= BUS_STORE;
                    r_addr <= w_head.addr;
                    r_data <= w_head.data;
                    r_size <= w_head.size;
                end else if (w_iss_found) begin
                    r_cmd     <= BUS_LOAD;
                    r_addr    <= {r_mshr[w_iss_idx].blk, 3'b000};
                    r_data    <= '0;
                    r_size    <= DOUBLE;
                    r_cmd_idx <= w_iss_idx;
                end
            end
        end
    end

    assign proc2mem_command = r_cmd;
    assign proc2mem_addr    = {16'h0000, r_addr};
    assign proc2mem_data    = r_data;
    assign proc2mem_size    = r_size;
    assign fill_en          = r_fill_en;
    assign fill_idx         = r_fill_idx;
    assign fill_tag         = r_fill_tag;
    assign fill_data        = r_fill_data;
    assign fill_gnt         = r_fill_gnt;
    assign overflow_err     = r_overflow;

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// tb_dcache_mem_ctrl
//   Directed bench for dcache_mem_ctrl. Stimulus pushes the expected memory
//   commands and fills into queues; a monitor on the falling edge pops and
//   compares whenever a command is accepted or a fill/wakeup is presented.
module tb_dcache_mem_ctrl;
    import dcache_mem_ctrl_pkg::*;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             wb_en, wr_en, rd_en;
    logic [15:0]      wb_addr, wr_addr, rd_addr;
    logic [63:0]      wb_data, wr_data;
    logic [1:0]       wb_size, wr_size, rd_size;
    logic [LSQSZ-1:0] rd_gnt;
    logic             mem_busy, overflow_err, fill_en;
    logic [4:0]       fill_idx;
    logic [7:0]       fill_tag;
    logic [63:0]      fill_data;
    logic [LSQSZ-1:0] fill_gnt;
    logic [1:0]       proc2mem_command, proc2mem_size;
    logic [31:0]      proc2mem_addr;
    logic [63:0]      proc2mem_data;
    logic [3:0]       mem2proc_response, mem2proc_tag;
    logic [63:0]      mem2proc_data;

    int n_cmp = 0;
    int n_err = 0;

    // {command, addr, data (0 for loads), size}
    logic [99:0] exp_cmd_q[$];
    // {fill_en, fill_idx, fill_tag, fill_data, fill_gnt}
    logic [81:0] exp_fill_q[$];
    logic [99:0] mon_cmd_got, mon_cmd_exp;
    logic [81:0] mon_fill_got, mon_fill_exp;

    dcache_mem_ctrl #(.NUM_MSHR(4), .STQ_DEPTH(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_size(wb_size),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_size(wr_size),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_size(rd_size), .rd_gnt(rd_gnt),
        .mem_busy(mem_busy), .overflow_err(overflow_err),
        .fill_en(fill_en), .fill_idx(fill_idx), .fill_tag(fill_tag),
        .fill_data(fill_data), .fill_gnt(fill_gnt),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data), .proc2mem_size(proc2mem_size),
        .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
        .mem2proc_tag(mem2proc_tag)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; wb_size = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_size = '0;
        rd_en = 1'b0; rd_addr = '0; rd_size = '0; rd_gnt = '0;
        mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic wait_cmd(input string name);
        int k = 0;
        while (proc2mem_command == BUS_NONE && k < 20) begin
            tick();
            k++;
        end
        if (proc2mem_command == BUS_NONE) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout waiting for command got=%h exp=nonzero", name, proc2mem_command);
        end
    endtask

    task automatic exp_store(input logic [15:0] a, input logic [63:0] d, input logic [1:0] s);
        exp_cmd_q.push_back({2'(BUS_STORE), 16'h0000, a, d, s});
    endtask

    task automatic exp_load(input logic [15:0] a);
        exp_cmd_q.push_back({2'(BUS_LOAD), 16'h0000, a, 64'h0, 2'(DOUBLE)});
    endtask

    task automatic exp_fill(input logic en, input logic [4:0] idx, input logic [7:0] tg,
                            input logic [63:0] d, input logic [LSQSZ-1:0] g);
        exp_fill_q.push_back({en, idx, tg, d, g});
    endtask

    task automatic read_req(input logic [15:0] a, input logic [LSQSZ-1:0] g);
        rd_en = 1'b1; rd_addr = a; rd_size = 2'(DOUBLE); rd_gnt = g;
        tick();
        rd_en = 1'b0; rd_addr = '0; rd_gnt = '0;
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (proc2mem_command != BUS_NONE && mem2proc_response != 4'h0) begin
                    mon_cmd_got = {proc2mem_command, proc2mem_addr,
                                   (proc2mem_command == BUS_STORE) ? proc2mem_data : 64'h0,
                                   proc2mem_size};
                    n_cmp++;
                    if (exp_cmd_q.size() == 0) begin
                        n_err++;
                        $display("FAIL cmd unexpected got=%h exp=none", mon_cmd_got);
                    end else begin
                        mon_cmd_exp = exp_cmd_q.pop_front();
                        if (mon_cmd_got !== mon_cmd_exp) begin
                            n_err++;
                            $display("FAIL cmd got=%h exp=%h", mon_cmd_got, mon_cmd_exp);
                        end
                    end
                end
                if (fill_en || fill_gnt != '0) begin
                    mon_fill_got = {fill_en, fill_idx, fill_tag, fill_data, fill_gnt};
                    n_cmp++;
                    if (exp_fill_q.size() == 0) begin
                        n_err++;
                        $display("FAIL fill unexpected got=%h exp=none", mon_fill_got);
                    end else begin
                        mon_fill_exp = exp_fill_q.pop_front();
                        if (mon_fill_got !== mon_fill_exp) begin
                            n_err++;
                            $display("FAIL fill got=%h exp=%h", mon_fill_got, mon_fill_exp);
                        end
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        clear_inputs();
        repeat (3) tick();
        check("rst_cmd_in_reset", 64'(proc2mem_command), 64'(BUS_NONE));
        reset_n = 1'b1;
        tick();
        check("rst_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        check("rst_addr", 64'(proc2mem_addr), 64'h0);
        check("rst_busy", 64'(mem_busy), 64'h0);
        check("rst_ovf", 64'(overflow_err), 64'h0);
        check("rst_fill", 64'({fill_en, fill_gnt}), 64'h0);

        // Store priority: wb and wr in one cycle, wb goes out first.
        exp_store(16'h0120, 64'h1111_2222_3333_4444, 2'(WORD));
        exp_store(16'h0348, 64'h5555_6666_7777_8888, 2'(DOUBLE));
        wb_en = 1'b1; wb_addr = 16'h0120; wb_data = 64'h1111_2222_3333_4444; wb_size = 2'(WORD);
        wr_en = 1'b1; wr_addr = 16'h0348; wr_data = 64'h5555_6666_7777_8888; wr_size = 2'(DOUBLE);
        tick();
        clear_inputs();
        mem2proc_response = 4'h1;
        repeat (8) tick();
        mem2proc_response = 4'h0;
        check("t1_idle", 64'(proc2mem_command), 64'(BUS_NONE));
        check("t1_busy", 64'(mem_busy), 64'h0);

        // Load round trip.
        exp_load(16'h1A08);
        exp_fill(1'b1, 5'd1, 8'h1A, 64'hDEAD_BEEF_CAFE_F00D, 4'b0010);
        read_req(16'h1A08, 4'b0010);
        wait_cmd("t2_wait");
        mem2proc_response = 4'h3;
        tick();
        mem2proc_response = 4'h0;
        mem2proc_tag = 4'h3; mem2proc_data = 64'hDEAD_BEEF_CAFE_F00D;
        tick();
        mem2proc_tag = 4'h0; mem2proc_data = '0;
        tick();
        check("t2_fill_one_cycle", 64'({fill_en, fill_gnt}), 64'h0);

        // Merge: two reads to the same block produce one load.
        exp_load(16'h1A08);
        exp_fill(1'b1, 5'd1, 8'h1A, 64'h0123_4567_89AB_CDEF, 4'b0101);
        read_req(16'h1A08, 4'b0001);
        read_req(16'h1A08, 4'b0100);
        wait_cmd("t3_wait");
        mem2proc_response = 4'h5;
        tick();
        mem2proc_response = 4'h0;
        repeat (3) tick();
        check("t3_single_load", 64'(proc2mem_command), 64'(BUS_NONE));
        mem2proc_tag = 4'h5; mem2proc_data = 64'h0123_4567_89AB_CDEF;
        tick();
        clear_inputs();
        repeat (2) tick();

        // Stale: store to an issued load's block suppresses the fill.
        exp_load(16'h0200);
        exp_store(16'h0204, 64'hAAAA_BBBB_CCCC_DDDD, 2'(WORD));
        exp_fill(1'b0, 5'd0, 8'h02, 64'hFEED_FACE_0000_1111, 4'b1000);
        read_req(16'h0200, 4'b1000);
        wait_cmd("t4_wait_load");
        mem2proc_response = 4'h7;
        tick();
        mem2proc_response = 4'h0;
        wr_en = 1'b1; wr_addr = 16'h0204; wr_data = 64'hAAAA_BBBB_CCCC_DDDD; wr_size = 2'(WORD);
        tick();
        clear_inputs();
        wait_cmd("t4_wait_store");
        mem2proc_response = 4'h1;
        tick();
        mem2proc_response = 4'h0;
        mem2proc_tag = 4'h7; mem2proc_data = 64'hFEED_FACE_0000_1111;
        tick();
        clear_inputs();
        repeat (2) tick();

        // Backpressure: command held while response stays 0; FIFO with one free slot is busy.
        exp_store(16'h0500, 64'h0000_0000_0000_00A5, 2'(BYTE));
        exp_store(16'h0508, 64'h0000_0000_0000_B6B6, 2'(HALF));
        exp_store(16'h0510, 64'h7777_0000_7777_0000, 2'(DOUBLE));
        wb_en = 1'b1; wb_addr = 16'h0500; wb_data = 64'h0000_0000_0000_00A5; wb_size = 2'(BYTE);
        wr_en = 1'b1; wr_addr = 16'h0508; wr_data = 64'h0000_0000_0000_B6B6; wr_size = 2'(HALF);
        tick();
        clear_inputs();
        wb_en = 1'b1; wb_addr = 16'h0510; wb_data = 64'h7777_0000_7777_0000; wb_size = 2'(DOUBLE);
        tick();
        clear_inputs();
        wait_cmd("t5_wait");
        check("t5_busy_fifo", 64'(mem_busy), 64'h1);
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_cmd", 64'(proc2mem_command), 64'(BUS_STORE));
            check("t5_hold_addr", 64'(proc2mem_addr), 64'h0000_0500);
            tick();
        end
        mem2proc_response = 4'h1;
        repeat (8) tick();
        mem2proc_response = 4'h0;
        check("t5_drained", 64'({mem_busy, proc2mem_command}), 64'h0);

        // Read in the same cycle its block's load returns: merged into the fill.
        exp_load(16'h3010);
        exp_fill(1'b1, 5'd2, 8'h30, 64'h3333_4444_5555_6666, 4'b0101);
        read_req(16'h3010, 4'b0001);
        wait_cmd("t7_wait");
        mem2proc_response = 4'h2;
        tick();
        mem2proc_response = 4'h0;
        mem2proc_tag = 4'h2; mem2proc_data = 64'h3333_4444_5555_6666;
        rd_en = 1'b1; rd_addr = 16'h3010; rd_size = 2'(DOUBLE); rd_gnt = 4'b0100;
        tick();
        clear_inputs();
        repeat (4) tick();
        check("t7_no_realloc", 64'(proc2mem_command), 64'(BUS_NONE));
        check("t7_busy", 64'(mem_busy), 64'h0);

        // Fill all MSHRs, overflow, then reset mid-flight.
        read_req(16'h1000, 4'b0001);
        read_req(16'h1008, 4'b0010);
        read_req(16'h1010, 4'b0100);
        check("t6_not_busy_3", 64'(mem_busy), 64'h0);
        read_req(16'h1018, 4'b1000);
        check("t6_busy_full", 64'(mem_busy), 64'h1);
        check("t6_no_ovf_yet", 64'(overflow_err), 64'h0);
        read_req(16'h1020, 4'b0001);
        check("t6_ovf", 64'(overflow_err), 64'h1);
        check("t6_cmd", 64'({proc2mem_command, proc2mem_addr}), {30'h0, 2'(BUS_LOAD), 32'h0000_1000});
        exp_load(16'h1000);
        mem2proc_response = 4'h9;
        tick();
        mem2proc_response = 4'h0;
        reset_n = 1'b0;
        #1;
        check("t6_rst_async", 64'({overflow_err, mem_busy, proc2mem_command}), 64'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check("t6_rst_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        check("t6_rst_ovf", 64'(overflow_err), 64'h0);
        check("t6_rst_busy", 64'(mem_busy), 64'h0);
        mem2proc_tag = 4'h9; mem2proc_data = 64'h9999_9999_9999_9999;
        tick();
        clear_inputs();
        check("t6_late_tag", 64'({fill_en, fill_gnt}), 64'h0);
        repeat (4) tick();

        check("end_cmd_q_empty", 64'(exp_cmd_q.size()), 64'h0);
        check("end_fill_q_empty", 64'(exp_fill_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
